// File: rtl/sync_s2f_stream.sv
// Buffers single-cycle data_set strobes from the slow-to-fast synchronizer into a valid/ready stream; 1-cycle push-to-head latency.
// Backpressure: words arriving while full (and no pop that cycle) are dropped and counted, never corrupting buffered data.
module sync_s2f_stream #(
    parameter int DATA_WIDTH     = 16,
    parameter int DEPTH          = 4,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                      fast_clk,
    input  logic                      fast_rst_n,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      in_data_set,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    input  logic                      overflow_clr,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] ONE_LVL  = LW'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;

    assign full      = (level == FULL_LVL);
    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign push      = in_data_set && (!full || pop);
    assign drop      = in_data_set && full && !pop;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge fast_clk) begin
        if (fast_rst_n && push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge fast_clk) begin
        if (!fast_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + ONE_LVL;
                2'b01:   level <= level - ONE_LVL;
                default: level <= level;
            endcase
            // A drop coinciding with a clear still records itself as the first new drop.
            if (drop) begin
                overflow <= 1'b1;
                if (overflow_clr) begin
                    drop_count <= DROP_CNT_WIDTH'(1);
                end else if (drop_count != '1) begin
                    drop_count <= drop_count + DROP_CNT_WIDTH'(1);
                end
            end else if (overflow_clr) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sync_s2f_stream.sv
module tb_sync_s2f_stream;

    logic        fast_clk = 1'b0;
    logic        fast_rst_n;
    logic [15:0] in_data;
    logic        in_data_set;
    logic        out_ready;
    logic        overflow_clr;

    logic [15:0] out_data;
    logic        out_valid;
    logic [2:0]  level;
    logic        overflow;
    logic [7:0]  drop_count;

    logic [15:0] s_out_data;
    logic        s_out_valid;
    logic [2:0]  s_level;
    logic        s_overflow;
    logic [1:0]  s_drop_count;

    always #5 fast_clk = ~fast_clk;

    sync_s2f_stream dut (
        .fast_clk     (fast_clk),
        .fast_rst_n   (fast_rst_n),
        .in_data      (in_data),
        .in_data_set  (in_data_set),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .level        (level),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .drop_count   (drop_count)
    );

    // Same stimulus, narrow counter: checks saturation at 3.
    sync_s2f_stream #(.DROP_CNT_WIDTH(2)) dut_sat (
        .fast_clk     (fast_clk),
        .fast_rst_n   (fast_rst_n),
        .in_data      (in_data),
        .in_data_set  (in_data_set),
        .out_data     (s_out_data),
        .out_valid    (s_out_valid),
        .out_ready    (out_ready),
        .level        (s_level),
        .overflow     (s_overflow),
        .overflow_clr (overflow_clr),
        .drop_count   (s_drop_count)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of buffered words plus a drop tally since last clear.
    logic [15:0] q[$];
    logic        m_ovf = 1'b0;
    int          m_drops = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        bit mpop, mfull, mpush, mdrop;
        if (!fast_rst_n) begin
            q.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            mfull = (q.size() == 4);
            mpop  = (q.size() != 0) && out_ready;
            mpush = in_data_set && (!mfull || mpop);
            mdrop = in_data_set && mfull && !mpop;
            if (mpop)  void'(q.pop_front());
            if (mpush) q.push_back(in_data);
            if (mdrop) begin
                m_ovf   = 1'b1;
                m_drops = overflow_clr ? 1 : m_drops + 1;
            end else if (overflow_clr) begin
                m_ovf   = 1'b0;
                m_drops = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, "_vld"},  32'(out_valid),    32'(n != 0));
        chk({tag, "_dat"},  32'(out_data),     (n != 0) ? 32'(q[0]) : 32'd0);
        chk({tag, "_lvl"},  32'(level),        32'(n));
        chk({tag, "_ovf"},  32'(overflow),     32'(m_ovf));
        chk({tag, "_cnt"},  32'(drop_count),   32'((m_drops > 255) ? 255 : m_drops));
        chk({tag, "_scnt"}, 32'(s_drop_count), 32'((m_drops > 3) ? 3 : m_drops));
        chk({tag, "_slvl"}, 32'(s_level),      32'(n));
    endtask

    task automatic step(input string tag, input logic s, input logic [15:0] d,
                        input logic r, input logic c, input logic rn);
        in_data_set  = s;
        in_data      = d;
        out_ready    = r;
        overflow_clr = c;
        fast_rst_n   = rn;
        @(posedge fast_clk);
        model_update();
        @(negedge fast_clk);
        check_all(tag);
    endtask

    initial begin
        in_data_set  = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        overflow_clr = 1'b0;
        fast_rst_n   = 1'b0;
        @(negedge fast_clk);

        step("reset", 0, 16'h0, 0, 0, 0);
        chk("reset_lvl_const", 32'(level), 32'd0);

        // Single word
        step("single_push", 1, 16'hA5C3, 1, 0, 1);
        chk("single_dat_const", 32'(out_data), 32'hA5C3);
        step("single_pop", 0, 16'h0, 1, 0, 1);
        chk("single_empty_const", 32'(out_valid), 32'd0);

        // Fill to full, then drain
        for (int i = 1; i <= 4; i++) step("fill", 1, 16'(i), 0, 0, 1);
        chk("fill_lvl_const", 32'(level), 32'd4);
        chk("fill_head_const", 32'(out_data), 32'd1);
        for (int i = 0; i < 4; i++) step("drain", 0, 16'h0, 1, 0, 1);

        // Overflow: 5 and 6 dropped
        for (int i = 1; i <= 4; i++) step("ovf_fill", 1, 16'(i), 0, 0, 1);
        step("ovf_drop5", 1, 16'd5, 0, 0, 1);
        step("ovf_drop6", 1, 16'd6, 0, 0, 1);
        chk("ovf_cnt_const", 32'(drop_count), 32'd2);
        for (int i = 0; i < 4; i++) step("ovf_drain", 0, 16'h0, 1, 0, 1);
        step("ovf_clr", 0, 16'h0, 0, 1, 1);

        // Push+pop at full
        for (int i = 1; i <= 4; i++) step("pp_fill", 1, 16'(i), 0, 0, 1);
        step("pp_full", 1, 16'd9, 1, 0, 1);
        chk("pp_lvl_const", 32'(level), 32'd4);
        chk("pp_head_const", 32'(out_data), 32'd2);
        for (int i = 0; i < 4; i++) step("pp_drain", 0, 16'h0, 1, 0, 1);

        // Clear vs drop, then saturation of the narrow counter
        for (int i = 1; i <= 4; i++) step("cd_fill", 1, 16'(i), 0, 0, 1);
        for (int i = 0; i < 3; i++) step("cd_drop", 1, 16'hEE, 0, 0, 1);
        chk("cd_cnt3_const", 32'(drop_count), 32'd3);
        step("cd_clr_drop", 1, 16'hEF, 0, 1, 1);
        chk("cd_cnt1_const", 32'(drop_count), 32'd1);
        step("cd_clr_only", 0, 16'h0, 0, 1, 1);
        chk("cd_ovf0_const", 32'(overflow), 32'd0);
        for (int i = 0; i < 5; i++) step("sat_drop", 1, 16'hDD, 0, 0, 1);
        chk("sat_cnt_const", 32'(s_drop_count), 32'd3);
        chk("sat_wide_const", 32'(drop_count), 32'd5);

        // Reset mid-operation with level=3 and overflow=1
        step("rm_pop", 0, 16'h0, 1, 0, 1);
        chk("rm_lvl3_const", 32'(level), 32'd3);
        step("rm_reset", 1, 16'hBEEF, 0, 0, 0);
        chk("rm_ovf_const", 32'(overflow), 32'd0);
        step("rm_push", 1, 16'h0042, 0, 0, 1);
        chk("rm_head_const", 32'(out_data), 32'h0042);
        step("rm_hold", 0, 16'h0, 0, 0, 1);
        step("rm_pop2", 0, 16'h0, 1, 0, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 1'($urandom_range(0, 2) != 0),
                 16'($urandom),
                 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 63) != 0));
        end
        for (int i = 0; i < 5; i++) step("final_drain", 0, 16'h0, 1, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
